// File: rtl/bus_regbank_slave.sv
// ============================================================================
// Module   : bus_regbank_slave
// Brief    : Pipelined bus slave exposing NUMREGS 32-bit R/W registers with
//            configurable wait states and a two-cycle error response.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_regbank_slave #(
    parameter int          NUMREGS    = 16,
    parameter int          WAITSTATES = 1,
    parameter logic [31:0] BASEADDR   = 32'h0
) (
    input  logic                    main_clk_i,
    input  logic                    main_rst_i,
    input  logic [1:0]              bus_trans_i,
    input  logic [31:0]             bus_addr_i,
    input  logic                    bus_write_i,
    input  logic [31:0]             bus_wdata_i,
    output logic                    bus_ready_o,
    output logic                    bus_resp_o,
    output logic [31:0]             bus_rdata_o,
    output logic [32*NUMREGS-1:0]   regs_o
);

    localparam int IW = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
    localparam int CW = (WAITSTATES > 0) ? $clog2(WAITSTATES + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t          state_q;
    logic            ready_q;
    logic            resp_q;
    logic [CW-1:0]   cnt_q;
    logic            write_q;
    logic [IW-1:0]   idx_q;
    logic [31:0]     regs_q [NUMREGS];

    logic [31:0]     w_off;
    logic            w_valid;
    logic            w_accept;
    logic [IW-1:0]   w_index;
    logic            w_unused_trans;

    // BASEADDR is word aligned, so the offset's low bits mirror the address's.
    assign w_off          = bus_addr_i - BASEADDR;
    assign w_valid        = (w_off[1:0] == 2'b00) && (bus_addr_i >= BASEADDR) &&
                            ({2'b00, w_off[31:2]} < 32'(NUMREGS));
    assign w_index        = w_off[IW+1:2];
    assign w_accept       = ready_q && bus_trans_i[1];
    assign w_unused_trans = bus_trans_i[0];

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            for (int i = 0; i < NUMREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (state_q == ST_DATA && write_q) begin
                regs_q[idx_q] <= bus_wdata_i;
            end

            case (state_q)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (w_accept) begin
                        write_q <= bus_write_i;
                        idx_q   <= w_index;
                        if (!w_valid) begin
                            state_q <= ST_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= 1'b1;
                        end else if (WAITSTATES == 0) begin
                            state_q <= ST_DATA;
                            ready_q <= 1'b1;
                            resp_q  <= 1'b0;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CW'(WAITSTATES);
                            ready_q <= 1'b0;
                            resp_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= ST_DATA;
                        ready_q <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state_q <= ST_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_ready_o = ready_q;
    assign bus_resp_o  = resp_q;
    assign bus_rdata_o = (state_q == ST_DATA && !write_q) ? regs_q[idx_q] : 32'h0;

    for (genvar g = 0; g < NUMREGS; g++) begin : g_regs_o
        assign regs_o[32*g +: 32] = regs_q[g];
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_regbank_slave.sv
// ============================================================================
// Module   : tb_bus_regbank_slave
// Brief    : Scoreboard bench for bus_regbank_slave (one DUT with one wait
//            state, one with zero wait states).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_regbank_slave;

    localparam int NR = 16;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic               clk;
    logic               rst    [2];
    logic [1:0]         trans  [2];
    logic [31:0]        addr   [2];
    logic               write  [2];
    logic [31:0]        wdata  [2];
    logic               ready  [2];
    logic               resp   [2];
    logic [31:0]        rdata  [2];
    logic [32*NR-1:0]   regs   [2];

    logic [31:0]        model  [2][NR];
    exp_t               q0[$];
    exp_t               q1[$];
    logic               pend   [2];
    int                 stall  [2];
    int                 passed;
    int                 total;

    bus_regbank_slave #(.NUMREGS(NR), .WAITSTATES(1), .BASEADDR(32'h0)) u_dut_ws1 (
        .main_clk_i (clk),      .main_rst_i (rst[0]),
        .bus_trans_i(trans[0]), .bus_addr_i (addr[0]),
        .bus_write_i(write[0]), .bus_wdata_i(wdata[0]),
        .bus_ready_o(ready[0]), .bus_resp_o (resp[0]),
        .bus_rdata_o(rdata[0]), .regs_o     (regs[0])
    );

    bus_regbank_slave #(.NUMREGS(NR), .WAITSTATES(0), .BASEADDR(32'h0)) u_dut_ws0 (
        .main_clk_i (clk),      .main_rst_i (rst[1]),
        .bus_trans_i(trans[1]), .bus_addr_i (addr[1]),
        .bus_write_i(write[1]), .bus_wdata_i(wdata[1]),
        .bus_ready_o(ready[1]), .bus_resp_o (resp[1]),
        .bus_rdata_o(rdata[1]), .regs_o     (regs[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_regs(input int d, input string tag);
        for (int i = 0; i < NR; i++) begin
            chk(tag, regs[d][32*i +: 32], model[d][i]);
        end
    endtask

    // Data-phase monitor: pops the scoreboard when a pending data phase completes.
    task automatic mon(input int d);
        exp_t e;
        if (rst[d]) begin
            pend[d]  = 1'b0;
            stall[d] = 0;
            if (d == 0) q0.delete(); else q1.delete();
            return;
        end
        if (pend[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                chk("sb_underflow", 32'd1, 32'd0);
                pend[d] = 1'b0;
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                if (ready[d]) begin
                    chk("resp",  {31'd0, resp[d]}, {31'd0, e.resp});
                    chk("rdata", rdata[d], e.rdata);
                    chk("waits", stall[d], e.waits);
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    pend[d] = 1'b0;
                end else begin
                    stall[d]++;
                    chk("stall_resp",  {31'd0, resp[d]}, {31'd0, e.resp});
                    chk("stall_rdata", rdata[d], 32'h0);
                end
            end
        end
        if (ready[d] && trans[d][1]) begin
            pend[d]  = 1'b1;
            stall[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic issue(input int d, input logic [1:0] tr, input logic [31:0] a,
                         input logic w, input logic [31:0] wd);
        exp_t e;
        logic valid;
        int   n;
        trans[d] = tr;
        addr[d]  = a;
        write[d] = w;
        valid    = (a[1:0] == 2'b00) && (a < 32'(4 * NR));
        e.resp   = !valid;
        e.waits  = !valid ? 1 : (d == 0 ? 1 : 0);
        e.rdata  = (valid && !w) ? model[d][a[5:2]] : 32'h0;
        if (valid && w) model[d][a[5:2]] = wd;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        n = 0;
        @(negedge clk);
        while (!ready[d] && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        wdata[d] = wd;
    endtask

    task automatic idle(input int d, input int cycles);
        trans[d] = 2'd0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; trans[d] = 2'd0; addr[d] = 32'h0;
            write[d] = 1'b0; wdata[d] = 32'h0; pend[d] = 1'b0; stall[d] = 0;
            for (int i = 0; i < NR; i++) model[d][i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'd0, ready[0]}, 32'd1);
        chk("rst_resp",  {31'd0, resp[0]},  32'd0);
        chk("rst_rdata", rdata[0], 32'h0);
        chk_regs(0, "rst_regs");
        @(posedge clk);
        #1;

        // One wait state read, then write/read back-to-back
        issue(0, 2'd2, 32'h08, 1'b0, 32'h0);
        issue(0, 2'd2, 32'h04, 1'b1, 32'hDEADBEEF);
        issue(0, 2'd2, 32'h04, 1'b0, 32'h0);
        issue(0, 2'd2, 32'h3C, 1'b1, 32'hA5A5_0F0F);
        issue(0, 2'd3, 32'h3C, 1'b0, 32'h0);
        idle(0, 3);
        chk("reg1_deadbeef", regs[0][63:32], 32'hDEADBEEF);

        // Bad addresses: out of range and misaligned writes
        issue(0, 2'd2, 32'h40, 1'b1, 32'h1111_1111);
        issue(0, 2'd2, 32'h02, 1'b1, 32'h2222_2222);
        issue(0, 2'd2, 32'hFFFF_FFFC, 1'b0, 32'h0);
        issue(0, 2'd2, 32'h04, 1'b0, 32'h0);
        idle(0, 3);
        chk_regs(0, "err_regs");

        // IDLE/BUSY with random addresses
        for (int i = 0; i < 8; i++) begin
            trans[0] = (i % 2 == 0) ? 2'd0 : 2'd1;
            addr[0]  = {$urandom_range(0, 15), 2'b00} & 32'h3C;
            write[0] = 1'b1;
            wdata[0] = $urandom;
            @(negedge clk);
            chk("idle_ready", {31'd0, ready[0]}, 32'd1);
            chk("idle_resp",  {31'd0, resp[0]},  32'd0);
            @(posedge clk);
            #1;
        end
        chk_regs(0, "idle_regs");

        // Zero wait states: writes then NONSEQ,SEQ,SEQ reads
        issue(1, 2'd2, 32'h00, 1'b1, 32'h0000_00AA);
        issue(1, 2'd3, 32'h04, 1'b1, 32'h0000_BB00);
        issue(1, 2'd3, 32'h08, 1'b1, 32'h00CC_0000);
        issue(1, 2'd2, 32'h00, 1'b0, 32'h0);
        issue(1, 2'd3, 32'h04, 1'b0, 32'h0);
        issue(1, 2'd3, 32'h08, 1'b0, 32'h0);
        issue(1, 2'd2, 32'h08, 1'b1, 32'h1234_5678);
        issue(1, 2'd2, 32'h08, 1'b0, 32'h0);
        issue(1, 2'd2, 32'h40, 1'b0, 32'h0);
        issue(1, 2'd2, 32'h3C, 1'b0, 32'h0);
        idle(1, 3);
        chk_regs(1, "ws0_regs");

        // Reset during the wait state of a write drops it
        issue(0, 2'd2, 32'h0C, 1'b1, 32'h0000_1234);
        rst[0]   = 1'b1;
        trans[0] = 2'd0;
        for (int i = 0; i < NR; i++) model[0][i] = 32'h0;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, ready[0]}, 32'd1);
        chk("rst_mid_resp",  {31'd0, resp[0]},  32'd0);
        chk("rst_mid_reg3",  regs[0][127:96], 32'h0);
        idle(0, 3);
        chk_regs(0, "rst_mid_regs");
        issue(0, 2'd2, 32'h0C, 1'b0, 32'h0);
        idle(0, 4);

        chk("sb_empty0", 32'(q0.size()), 32'd0);
        chk("sb_empty1", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
